// File: rtl/color_sensor_emu_if.sv
// Pin bundle of the emulated colour sensor: filter/scale selects, enable, config port, output.
// Optional COLOR_EMU_PULSE_CNT_EN adds the pulse_count observation output.
interface color_sensor_emu_if;
    logic        select0;
    logic        select1;
    logic        select2;
    logic        select3;
    logic        EO;
    logic        cfg_valid;
    logic [1:0]  cfg_sel;
    logic [15:0] cfg_data;
    logic        cfg_ready;
    logic        freqOut;
`ifdef COLOR_EMU_PULSE_CNT_EN
    logic [15:0] pulse_count;
`endif

    modport master (
`ifdef COLOR_EMU_PULSE_CNT_EN
        input  pulse_count,
`endif
        output select0, select1, select2, select3, EO,
        output cfg_valid, cfg_sel, cfg_data,
        input  cfg_ready, freqOut
    );

    modport slave (
`ifdef COLOR_EMU_PULSE_CNT_EN
        output pulse_count,
`endif
        input  select0, select1, select2, select3, EO,
        input  cfg_valid, cfg_sel, cfg_data,
        output cfg_ready, freqOut
    );
endinterface

// File: rtl/color_sensor_emu.sv
// Colour light-to-frequency sensor emulator: square wave whose half-period is the selected
// channel's base value times the output scale. COLOR_EMU_PULSE_CNT_EN adds a rising-edge counter.
module color_sensor_emu (
    input logic               clk,
    input logic               rst_n,
    color_sensor_emu_if.slave bus
);
    typedef enum logic [0:0] {StIdle, StPend} state_e;

    state_e           state_q, state_d;
    logic [3:0][15:0] base_q, base_d;
    logic [15:0]      shadow_q, shadow_d;
    logic [1:0]       pend_sel_q, pend_sel_d;
    logic [21:0]      cnt_q, cnt_d;
    logic             freq_q, freq_d;
    logic [1:0]       ch_q, sc_q;

    logic [1:0]  ch, sc;
    logic [5:0]  mult;
    logic [21:0] eff;
    logic        hold, changed, toggle;

    assign ch = {bus.select2, bus.select3};
    assign sc = {bus.select0, bus.select1};

    always_comb begin
        mult = 6'd0;
        unique case (sc)
            2'b00: mult = 6'd0;
            2'b01: mult = 6'd50;
            2'b10: mult = 6'd5;
            2'b11: mult = 6'd1;
        endcase
    end

    assign eff     = {6'd0, base_q[ch]} * {16'd0, mult};
    assign hold    = bus.EO | (sc == 2'b00) | (eff == 22'd0);
    assign changed = (ch != ch_q) | (sc != sc_q);
    assign toggle  = !hold && !changed && (cnt_q == eff - 22'd1);

    // Output divider: any decode change restarts the half-period but keeps the level.
    always_comb begin
        cnt_d  = cnt_q + 22'd1;
        freq_d = freq_q;
        if (hold) begin
            cnt_d  = 22'd0;
            freq_d = 1'b0;
        end else if (changed) begin
            cnt_d = 22'd0;
        end else if (toggle) begin
            cnt_d  = 22'd0;
            freq_d = ~freq_q;
        end
    end

    // Writes to the live channel wait in the shadow so the running half-period is untouched.
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        shadow_d   = shadow_q;
        pend_sel_d = pend_sel_q;
        unique case (state_q)
            StIdle: begin
                if (bus.cfg_valid) begin
                    if (bus.cfg_sel != ch) begin
                        base_d[bus.cfg_sel] = bus.cfg_data;
                    end else begin
                        shadow_d   = bus.cfg_data;
                        pend_sel_d = bus.cfg_sel;
                        state_d    = StPend;
                    end
                end
            end
            StPend: begin
                if (toggle || changed || hold) begin
                    base_d[pend_sel_q] = shadow_q;
                    state_d            = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            base_q     <= '0;
            shadow_q   <= '0;
            pend_sel_q <= '0;
            cnt_q      <= '0;
            freq_q     <= 1'b0;
            ch_q       <= '0;
            sc_q       <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            shadow_q   <= shadow_d;
            pend_sel_q <= pend_sel_d;
            cnt_q      <= cnt_d;
            freq_q     <= freq_d;
            ch_q       <= ch;
            sc_q       <= sc;
        end
    end

    assign bus.cfg_ready = (state_q == StIdle);
    assign bus.freqOut   = freq_q;

`ifdef COLOR_EMU_PULSE_CNT_EN
    logic [15:0] pc_q, pc_d;

    always_comb begin
        pc_d = pc_q;
        if (changed) begin
            pc_d = 16'd0;
        end else if (toggle && !freq_q) begin
            pc_d = pc_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= 16'd0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign bus.pulse_count = pc_q;
`endif
endmodule
